sram_req_ctrl: RTL and testbench

- Initiator-side controller that drives the pins of a generic single-port SRAM macro (CSB/WEB/OEB/A/I/WBM in, O out).
- Converts a val/rdy memory request stream into SRAM pin activity.
- Returns a val/rdy response stream with a 1-cycle SRAM read latency, absorbing response backpressure in a small response queue.
- Sits between a cache or test source and the SRAM wrapper.

---
 rtl/sram_req_ctrl.sv | 111 +++++++++++
 tb/tb_sram_req_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: val/rdy request stream to single-port SRAM pins, with a queued val/rdy response path.
// Optional build macro SRAM_REQ_CTRL_RESP_BYPASS_EN lets a stage-1 response skip an empty queue (latency 1 instead of 2).
module sram_req_ctrl #(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 256,
    parameter int p_resp_depth  = 2,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_type,
    input  logic [c_addr_nbits-1:0]  req_addr,
    input  logic [p_data_nbits-1:0]  req_data,
    input  logic [c_data_nbytes-1:0] req_wmask,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_type,
    output logic [p_data_nbits-1:0]  resp_data,
    output logic                     sram_csb,
    output logic                     sram_web,
    output logic                     sram_oeb,
    output logic [c_addr_nbits-1:0]  sram_a,
    output logic [p_data_nbits-1:0]  sram_i,
    output logic [c_data_nbytes-1:0] sram_wbm,
    input  logic [p_data_nbits-1:0]  sram_o
);
    localparam int c_ptr_nbits = $clog2(p_resp_depth);
    localparam int c_cnt_nbits = $clog2(p_resp_depth + 1);
    localparam logic [c_cnt_nbits:0]   c_depth = (c_cnt_nbits + 1)'(p_resp_depth);
    localparam logic [c_ptr_nbits-1:0] c_last  = c_ptr_nbits'(p_resp_depth - 1);

    logic                    s1_val_q, s1_val_d;
    logic                    s1_type_q, s1_type_d;
    logic [c_addr_nbits-1:0] a_q, a_d;
    logic [p_data_nbits-1:0] i_q, i_d;
    logic [c_ptr_nbits-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_ptr_nbits-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_cnt_nbits-1:0]  count_q, count_d;
    logic                    mem_type_q [p_resp_depth];
    logic [p_data_nbits-1:0] mem_data_q [p_resp_depth];
    logic [p_data_nbits-1:0] s1_data;
    logic [c_cnt_nbits:0]    occ;
    logic                    enq, pop, deq, fire;

    // response selection, flow control, SRAM pin drive and next-state
    always_comb begin
        s1_data = s1_type_q ? '0 : sram_o;
`ifdef SRAM_REQ_CTRL_RESP_BYPASS_EN
        resp_val  = s1_val_q || count_q != '0;
        resp_type = count_q == '0 ? s1_type_q : mem_type_q[rd_ptr_q];
        resp_data = count_q == '0 ? s1_data : mem_data_q[rd_ptr_q];
        enq       = s1_val_q && !(count_q == '0 && resp_rdy);
        pop       = count_q != '0 && resp_rdy;
`else
        resp_val  = count_q != '0;
        resp_type = mem_type_q[rd_ptr_q];
        resp_data = mem_data_q[rd_ptr_q];
        enq       = s1_val_q;
        pop       = resp_val && resp_rdy;
`endif
        deq       = resp_val && resp_rdy;
        occ       = {1'b0, count_q} + (c_cnt_nbits + 1)'(s1_val_q);
        req_rdy   = reset_n && (occ - (c_cnt_nbits + 1)'(deq) < c_depth);
        fire      = req_val && req_rdy;
        sram_csb  = !fire;
        sram_web  = !(fire && req_type);
        sram_wbm  = fire && req_type ? req_wmask : '0;
        sram_a    = fire ? req_addr : a_q;
        sram_i    = fire && req_type ? req_data : i_q;
        sram_oeb  = !(s1_val_q && !s1_type_q);
        a_d       = sram_a;
        i_d       = sram_i;
        s1_val_d  = fire;
        s1_type_d = fire ? req_type : s1_type_q;
        wr_ptr_d  = enq ? (wr_ptr_q == c_last ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d  = pop ? (rd_ptr_q == c_last ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d   = count_q + c_cnt_nbits'(enq) - c_cnt_nbits'(pop);
    end

    // control state; reset drops the in-flight request and empties the queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_val_q  <= 1'b0;
            s1_type_q <= 1'b0;
            a_q       <= '0;
            i_q       <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            s1_val_q  <= s1_val_d;
            s1_type_q <= s1_type_d;
            a_q       <= a_d;
            i_q       <= i_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // response storage; contents are meaningless unless counted
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_type_q[wr_ptr_q] <= s1_type_q;
            mem_data_q[wr_ptr_q] <= s1_data;
        end
    end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: scoreboard bench for sram_req_ctrl with a behavioural SRAM.
module tb_sram_req_ctrl;
`ifdef SRAM_REQ_CTRL_RESP_BYPASS_EN
    localparam bit bypass = 1'b1;
`else
    localparam bit bypass = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_val = 1'b0, req_rdy, req_type = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_wmask = '0;
    logic        resp_val, resp_rdy = 1'b1, resp_type;
    logic [31:0] resp_data;
    logic        sram_csb, sram_web, sram_oeb;
    logic [7:0]  sram_a;
    logic [31:0] sram_i, sram_o, sram_o_q;
    logic [3:0]  sram_wbm;

    typedef struct {
        logic        t;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] last_data;
    int          n_tests = 0, n_fail = 0, cyc = 0;
    int          resp_cnt = 0, first_cyc = 0, last_cyc = 0, stall = 0, stalls = 0, acc = 0;

    always #5 clk = ~clk;

    sram_req_ctrl #(.p_data_nbits(32), .p_num_entries(256), .p_resp_depth(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data), .req_wmask(req_wmask),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type), .resp_data(resp_data),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
        .sram_a(sram_a), .sram_i(sram_i), .sram_wbm(sram_wbm), .sram_o(sram_o)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // behavioural SRAM: synchronous read/write, output only driven while OEB is low
    assign sram_o = sram_oeb ? 32'hx : sram_o_q;
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) sram_mem[sram_a] = merge(sram_mem[sram_a], sram_i, sram_wbm);
            else sram_o_q <= sram_mem[sram_a];
        end
    end

    always @(posedge clk) cyc++;

    // scoreboard: push on request fire, pop and compare on response fire
    always @(negedge clk) begin
        if (reset_n && req_val && req_rdy) begin
            if (req_type) begin
                ref_mem[req_addr] = merge(ref_mem[req_addr], req_data, req_wmask);
                exp_q.push_back('{1'b1, 32'h0});
            end else exp_q.push_back('{1'b0, ref_mem[req_addr]});
        end
        if (reset_n && resp_val && resp_rdy) begin
            resp_cnt++;
            if (resp_cnt == 1) first_cyc = cyc;
            last_cyc  = cyc;
            last_data = resp_data;
            if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("resp_type", resp_type, mon_e.t);
                check("resp_data", resp_data, mon_e.d);
            end
        end
    end

    task automatic send(input logic t, input logic [7:0] a, input logic [31:0] d, input logic [3:0] m, output int st);
        bit ok;
        ok = 0;
        st = 0;
        req_val = 1; req_type = t; req_addr = a; req_data = d; req_wmask = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_rdy) begin ok = 1; break; end
            st++;
            @(posedge clk); #1;
        end
        if (!ok) check("req_timeout", 0, 1);
        @(posedge clk); #1;
        req_val = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A0000C3;
            ref_mem[i]  = 32'(i) * 32'h01010101 ^ 32'h5A0000C3;
        end
        repeat (2) @(negedge clk);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_csb", sram_csb, 1);
        check("rst_web", sram_web, 1);
        check("rst_oeb", sram_oeb, 1);
        check("rst_wbm", sram_wbm, 0);
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        check("idle_req_rdy", req_rdy, 1);

        // write then read with latency and pin checks
        @(posedge clk); #1;
        req_val = 1; req_type = 1; req_addr = 8'h05; req_data = 32'hDEADBEEF; req_wmask = 4'hF;
        @(negedge clk);
        check("wr_csb", sram_csb, 0);
        check("wr_web", sram_web, 0);
        check("wr_a", sram_a, 8'h05);
        check("wr_i", sram_i, 32'hDEADBEEF);
        check("wr_wbm", sram_wbm, 4'hF);
        @(posedge clk); #1;
        req_val = 0;
        @(negedge clk);
        check("wr_n1_resp_val", resp_val, bypass);
        check("idle_csb", sram_csb, 1);
        check("idle_web", sram_web, 1);
        check("idle_wbm", sram_wbm, 0);
        check("idle_a_held", sram_a, 8'h05);
        @(posedge clk); #1;
        @(negedge clk);
        check("wr_n2_resp_val", resp_val, !bypass);
        @(posedge clk); #1;
        req_val = 1; req_type = 0; req_addr = 8'h05;
        @(negedge clk);
        check("rd_csb", sram_csb, 0);
        check("rd_web", sram_web, 1);
        check("rd_wbm", sram_wbm, 0);
        @(posedge clk); #1;
        req_val = 0;
        @(negedge clk);
        check("rd_oeb", sram_oeb, 0);
        check("rd_n1_resp_val", resp_val, bypass);
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_n2_oeb", sram_oeb, 1);
        check("rd_n2_resp_val", resp_val, !bypass);
        drain();
        check("rd_data", last_data, 32'hDEADBEEF);

        // partial byte mask
        send(1, 8'h07, 32'h11223344, 4'hF, stall);
        send(1, 8'h07, 32'hAABBCCDD, 4'h2, stall);
        send(0, 8'h07, 32'h0, 4'h0, stall);
        drain();
        check("pmask_data", last_data, 32'h1122CC44);

        // back-to-back reads
        resp_cnt = 0;
        stalls = 0;
        for (int a = 0; a < 16; a++) begin
            send(0, 8'(a), 32'h0, 4'h0, stall);
            stalls += stall;
        end
        drain();
        check("b2b_stalls", stalls, 0);
        check("b2b_count", resp_cnt, 16);
        check("b2b_span", last_cyc - first_cyc, 15);

        // backpressure fills the queue
        resp_rdy = 0;
        acc = 0;
        req_val = 1; req_type = 0; req_addr = 8'h20;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_rdy) acc++;
            @(posedge clk); #1;
            req_addr = 8'(8'h20 + acc);
        end
        @(negedge clk);
        check("bp_accepted", acc, 2);
        check("bp_req_rdy", req_rdy, 0);
        check("bp_csb", sram_csb, 1);
        @(posedge clk); #1;
        req_val = 0;
        resp_cnt = 0;
        resp_rdy = 1;
        drain();
        check("bp_drained", resp_cnt, 2);

        // reset in the middle of a read
        send(0, 8'h05, 32'h0, 4'h0, stall);
        reset_n = 0;
        #1;
        check("mrst_resp_val", resp_val, 0);
        check("mrst_req_rdy", req_rdy, 0);
        check("mrst_csb", sram_csb, 1);
        check("mrst_oeb", sram_oeb, 1);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        check("post_rst_resp_val", resp_val, 0);
        @(posedge clk); #1;
        send(0, 8'h07, 32'h0, 4'h0, stall);
        drain();
        check("post_rst_data", last_data, 32'h1122CC44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
